// File: rtl/mips_pkg.sv
// Shared types for the fetch/decode/execute datapath.
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {inst, pc} entries.
// Flush takes priority over push and pop.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iPush,
    input  logic          iPop,
    input  logic          iFlush,
    input  fetch_entry_t  iData,
    output fetch_entry_t  oData,
    output logic          oEmpty,
    output logic          oFull,
    output logic [CW-1:0] oCount
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iFlush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (iPush) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (iPop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({iPush, iPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge iClk) begin
        if (iPush && !iFlush) r_mem[r_wr_ptr] <= iData;
    end

    assign oData  = r_mem[r_rd_ptr];
    assign oEmpty = (r_count == '0);
    assign oFull  = (r_count == CW'(DEPTH));
    assign oCount = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response buffering and
// redirect handling with stale-response dropping.
module fetch_unit
    import mips_pkg::*;
#(
    parameter word_t RESET_PC   = DEFAULT_RESET_PC,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic        iClk,
    input  logic        iReset,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemGnt,
    input  logic        iImemRvalid,
    input  logic [31:0] iImemRdata,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    output logic        oInstValid,
    output logic [31:0] oInst,
    output logic [31:0] oInstPc,
    input  logic        iInstReady
);

    localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    word_t         r_pc;
    word_t         r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_live;
    logic [CW-1:0] w_credit_used;
    logic [FW-1:0] w_fifo_count;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    fetch_entry_t  w_fifo_head;
    fetch_entry_t  w_push_entry;
    logic          w_req;
    logic          w_fire;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_inst_valid;
    logic          w_pop;
    word_t         w_redirect_pc;
    logic          w_unused_pc_lsbs;

    assign w_live        = r_outstanding - r_drop_cnt;
    assign w_credit_used = CW'(w_fifo_count) + w_live;
    assign w_req         = !iReset && !iRedirect && (w_credit_used < CW'(FIFO_DEPTH));
    assign w_fire        = w_req && iImemGnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp        = iImemRvalid && (r_outstanding != '0);
    assign w_drop        = w_resp && (r_drop_cnt != '0);
    assign w_push        = w_resp && (r_drop_cnt == '0) && !iRedirect;
    assign w_inst_valid  = !w_fifo_empty && !iRedirect && !iReset;
    assign w_pop         = w_inst_valid && iInstReady;
    assign w_redirect_pc = {iRedirectPc[31:2], 2'b00};
    assign w_unused_pc_lsbs = ^iRedirectPc[1:0];
    assign w_push_entry  = '{inst: iImemRdata, pc: r_resp_pc};

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_resp);
            if (iRedirect) begin
                r_pc       <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                // Everything in flight is stale, except a response consumed right now.
                r_drop_cnt <= r_outstanding - CW'(w_resp);
            end else begin
                if (w_fire) r_pc      <= r_pc + 32'd4;
                if (w_push) r_resp_pc <= r_resp_pc + 32'd4;
                if (w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .iClk   (iClk),
        .iReset (iReset),
        .iPush  (w_push),
        .iPop   (w_pop),
        .iFlush (iRedirect),
        .iData  (w_push_entry),
        .oData  (w_fifo_head),
        .oEmpty (w_fifo_empty),
        .oFull  (w_fifo_full),
        .oCount (w_fifo_count)
    );

    assign oImemReq   = w_req;
    assign oImemAddr  = r_pc;
    assign oInstValid = w_inst_valid;
    assign oInst      = w_fifo_empty ? 32'h0 : w_fifo_head.inst;
    assign oInstPc    = w_fifo_empty ? 32'h0 : w_fifo_head.pc;

    a_no_push_full: assert property (@(posedge iClk) disable iff (iReset)
        !(w_push && w_fifo_full));
    a_no_orphan_rvalid: assert property (@(posedge iClk) disable iff (iReset)
        !(iImemRvalid && (r_outstanding == '0)));

endmodule
